mire_writer: RTL and testbench



---
 rtl/mire_pkg.sv | 25 ++
 rtl/wshb_if.sv | 33 +++
 rtl/mire_pixel.sv | 31 +++
 rtl/mire_writer.sv | 144 ++++++++++++++
 tb/tb_mire_writer.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mire_pkg.sv
// Shared types and constants for the test-pattern writer.
package mire_pkg;

    typedef enum logic {IDLE, WRITE} mire_state_t;

    // Colour bars left to right, {R,G,B}.
    localparam logic [23:0] BAR_RGB [8] = '{
        24'hFFFFFF,  // white
        24'hFFFF00,  // yellow
        24'h00FFFF,  // cyan
        24'h00FF00,  // green
        24'hFF00FF,  // magenta
        24'hFF0000,  // red
        24'h0000FF,  // blue
        24'h000000   // black
    };

    localparam logic [23:0] SQ_RGB = 24'h808080;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wshb_if.sv
// Classic Wishbone bus bundle shared by the framebuffer masters and the SDRAM slave.
interface wshb_if #(
    parameter int unsigned DATA_BYTES = 4,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input logic clk,
    input logic rst
);

    logic [8*DATA_BYTES-1:0] dat_ms;
    logic [8*DATA_BYTES-1:0] dat_sm;
    logic [ADDR_WIDTH-1:0]   adr;
    logic                    cyc;
    logic [DATA_BYTES-1:0]   sel;
    logic                    stb;
    logic                    we;
    logic                    ack;
    logic                    err;
    logic                    rty;
    logic [2:0]              cti;
    logic [1:0]              bte;

    modport master (
        input  clk, rst, ack, err, rty, dat_sm,
        output dat_ms, adr, cyc, sel, stb, we, cti, bte
    );

    modport slave (
        input  clk, rst, dat_ms, adr, cyc, sel, stb, we, cti, bte,
        output ack, err, rty, dat_sm
    );

endinterface

// File: rtl/mire_pixel.sv
// Colour of one pixel of the test pattern: bar colour, overridden by the grey square.
module mire_pixel
    import mire_pkg::*;
#(
    parameter int unsigned HDISP = 800,
    parameter int unsigned VDISP = 480,
    parameter int unsigned SQ    = 32,
    parameter int unsigned XW    = 10,
    parameter int unsigned YW    = 9
) (
    input  logic [XW-1:0] x_i,
    input  logic [YW-1:0] y_i,
    input  logic [2:0]    bar_i,
    input  logic [XW-1:0] sq_x_i,
    output logic [31:0]   rgb_o
);

    // Square is vertically centred and never moves in y.
    localparam int unsigned SQ_Y = (VDISP - SQ) / 2;

    logic in_x;
    logic in_y;

    // Square hit test in 32-bit so sq_x+SQ cannot overflow the x width.
    always_comb begin
        in_x  = (32'(x_i) >= 32'(sq_x_i)) && (32'(x_i) < 32'(sq_x_i) + SQ);
        in_y  = (32'(y_i) >= SQ_Y) && (32'(y_i) < SQ_Y + SQ);
        rgb_o = {8'h00, (in_x && in_y) ? SQ_RGB : BAR_RGB[bar_i]};
    end

endmodule

// File: rtl/mire_writer.sv
// Wishbone write master that paints colour bars plus a moving grey square into the framebuffer.
module mire_writer
    import mire_pkg::*;
#(
    parameter int unsigned HDISP     = 800,
    parameter int unsigned VDISP     = 480,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned SQ        = 32,
    parameter int unsigned STEP      = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   start,
    input  logic   auto_run,
    output logic   busy,
    output logic   frame_done,
    wshb_if.master wshb_ifm
);

    localparam int unsigned XW = clog2_min1(HDISP);
    localparam int unsigned YW = clog2_min1(VDISP);
    localparam int unsigned SW = clog2_min1(HDISP / 8);

    mire_state_t   state_q;
    logic          cyc_q;
    logic          frame_done_q;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [SW-1:0] sub_q, sub_d;
    logic [2:0]    bar_q, bar_d;
    logic [XW-1:0] sq_x_q, sq_x_d;
    logic [31:0]   adr_q;
    logic [31:0]   dat_q;
    logic [31:0]   pix_rgb;
    logic          last_x;
    logic          frame_end;
    logic [31:0]   sq_sum;

    // Coordinates of the pixel that follows the current one (origin when idle).
    always_comb begin
        last_x    = (x_q == XW'(HDISP - 1));
        frame_end = last_x && (y_q == YW'(VDISP - 1));
        x_d       = '0;
        y_d       = '0;
        sub_d     = '0;
        bar_d     = '0;
        if (state_q == WRITE) begin
            if (last_x) begin
                y_d = y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
                y_d = y_q;
                if (sub_q == SW'(HDISP / 8 - 1)) begin
                    bar_d = bar_q + 3'd1;
                end else begin
                    sub_d = sub_q + SW'(1);
                    bar_d = bar_q;
                end
            end
        end
    end

    // Square position for the next frame, wrapping once it would leave the line.
    always_comb begin
        sq_sum = 32'(sq_x_q) + STEP;
        sq_x_d = (sq_sum > HDISP - SQ) ? '0 : XW'(sq_sum);
    end

    mire_pixel #(
        .HDISP (HDISP),
        .VDISP (VDISP),
        .SQ    (SQ),
        .XW    (XW),
        .YW    (YW)
    ) u_pixel (
        .x_i    (x_d),
        .y_i    (y_d),
        .bar_i  (bar_d),
        .sq_x_i (sq_x_q),
        .rgb_o  (pix_rgb)
    );

    // Frame FSM; counters, address and data are registered together on each ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cyc_q        <= 1'b0;
            frame_done_q <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            sub_q        <= '0;
            bar_q        <= '0;
            sq_x_q       <= '0;
            adr_q        <= BASE_ADDR;
            dat_q        <= '0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start || auto_run) begin
                        state_q <= WRITE;
                        cyc_q   <= 1'b1;
                        x_q     <= x_d;
                        y_q     <= y_d;
                        sub_q   <= sub_d;
                        bar_q   <= bar_d;
                        adr_q   <= BASE_ADDR;
                        dat_q   <= pix_rgb;
                    end
                end
                WRITE: begin
                    if (wshb_ifm.ack) begin
                        if (frame_end) begin
                            state_q      <= IDLE;
                            cyc_q        <= 1'b0;
                            frame_done_q <= 1'b1;
                            sq_x_q       <= sq_x_d;
                        end else begin
                            x_q   <= x_d;
                            y_q   <= y_d;
                            sub_q <= sub_d;
                            bar_q <= bar_d;
                            adr_q <= adr_q + 32'd4;
                            dat_q <= pix_rgb;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wshb_ifm.cyc    = cyc_q;
    assign wshb_ifm.stb    = cyc_q;
    assign wshb_ifm.we     = 1'b1;
    assign wshb_ifm.sel    = '1;
    assign wshb_ifm.cti    = 3'b000;
    assign wshb_ifm.bte    = 2'b00;
    assign wshb_ifm.adr    = adr_q;
    assign wshb_ifm.dat_ms = dat_q;
    assign busy            = cyc_q;
    assign frame_done      = frame_done_q;

endmodule

// File: tb/tb_mire_writer.sv
// Bench for mire_writer: Wishbone slave model with a write scoreboard plus per-feature tasks.
module tb_mire_writer;

    localparam int HDISP = 16;
    localparam int VDISP = 8;
    localparam int SQ    = 4;
    localparam int STEP  = 4;
    localparam int NPIX  = HDISP * VDISP;
    localparam logic [31:0] BASE = 32'h0;
    localparam logic [31:0] LAST_ADR = BASE + 32'(4 * (NPIX - 1));

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic auto_run = 1'b0;
    logic busy;
    logic frame_done;

    wshb_if wb (.clk(clk), .rst(~rst_n));

    mire_writer #(
        .HDISP     (HDISP),
        .VDISP     (VDISP),
        .BASE_ADDR (BASE),
        .SQ        (SQ),
        .STEP      (STEP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .auto_run   (auto_run),
        .busy       (busy),
        .frame_done (frame_done),
        .wshb_ifm   (wb)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_fail = 0;
    logic [63:0] sb_q[$];
    int          ack_cnt = 0;
    int          fd_cnt = 0;
    int          cyc_hi_cnt = 0;
    bit          rand_mode = 0;
    int          wait_left = 0;
    int          m_sqx = 0;
    logic        ack_r = 1'b0;
    logic        prev_cyc = 1'b0;
    logic [31:0] prev_adr = '0;
    logic [31:0] prev_dat = '0;
    logic [31:0] last_pop_adr = '0;

    // Reference pixel colour computed from absolute coordinates.
    function automatic logic [31:0] exp_pix(input int x, input int y, input int sqx);
        logic [23:0] c;
        int sqy;
        sqy = (VDISP - SQ) / 2;
        if (x >= sqx && x < sqx + SQ && y >= sqy && y < sqy + SQ) c = 24'h808080;
        else begin
            case (x / (HDISP / 8))
                0: c = 24'hFFFFFF;
                1: c = 24'hFFFF00;
                2: c = 24'h00FFFF;
                3: c = 24'h00FF00;
                4: c = 24'hFF00FF;
                5: c = 24'hFF0000;
                6: c = 24'h0000FF;
                default: c = 24'h000000;
            endcase
        end
        return {8'h00, c};
    endfunction

    // Queue every write of one frame and advance the modelled square position.
    task automatic push_frame();
        for (int y = 0; y < VDISP; y++)
            for (int x = 0; x < HDISP; x++)
                sb_q.push_back({BASE + 32'(4 * (y * HDISP + x)), exp_pix(x, y, m_sqx)});
        m_sqx = (m_sqx + STEP > HDISP - SQ) ? 0 : m_sqx + STEP;
    endtask

    // Slave model and bus monitor, evaluated away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_done === 1'b1) begin
                fd_cnt++;
                n_vec++;
                if (!(ack_r === 1'b1 && last_pop_adr === LAST_ADR && wb.cyc === 1'b0)) begin
                    n_fail++;
                    $display("FAIL frame_done_timing: ack=%b last_adr=%h cyc=%b, required ack=1 last_adr=%h cyc=0",
                             ack_r, last_pop_adr, wb.cyc, LAST_ADR);
                end
            end
            n_vec++;
            if (busy !== wb.cyc || wb.stb !== wb.cyc) begin
                n_fail++;
                $display("FAIL busy_stb_cyc: busy=%b stb=%b cyc=%b, required all equal", busy, wb.stb, wb.cyc);
            end
            if (wb.cyc === 1'b1) cyc_hi_cnt++;
            if (wb.cyc === 1'b1 && prev_cyc === 1'b1 && ack_r === 1'b0) begin
                n_vec++;
                if (wb.adr !== prev_adr || wb.dat_ms !== prev_dat) begin
                    n_fail++;
                    $display("FAIL hold_stable: adr=%h dat=%h, required adr=%h dat=%h",
                             wb.adr, wb.dat_ms, prev_adr, prev_dat);
                end
            end
            prev_cyc = wb.cyc;
            prev_adr = wb.adr;
            prev_dat = wb.dat_ms;
            if (wb.cyc === 1'b1 && wb.stb === 1'b1) begin
                if (wait_left == 0) begin
                    ack_r = 1'b1;
                    ack_cnt++;
                    n_vec++;
                    last_pop_adr = wb.adr;
                    if (sb_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_write: adr=%h dat=%h, required no write", wb.adr, wb.dat_ms);
                    end else begin
                        logic [63:0] e;
                        e = sb_q.pop_front();
                        if ({wb.adr, wb.dat_ms} !== e) begin
                            n_fail++;
                            $display("FAIL write: adr=%h dat=%h, required adr=%h dat=%h",
                                     wb.adr, wb.dat_ms, e[63:32], e[31:0]);
                        end
                    end
                    wait_left = rand_mode ? int'($urandom_range(0, 5)) : 0;
                end else begin
                    ack_r = 1'b0;
                    wait_left--;
                end
            end else begin
                ack_r = 1'b0;
            end
        end else begin
            ack_r    = 1'b0;
            prev_cyc = 1'b0;
        end
        wb.ack = ack_r;
    end

    task automatic wait_fd(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (frame_done === 1'b1) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic apply_reset();
        #2;
        rst_n = 1'b0;
        start = 1'b0;
        auto_run = 1'b0;
        sb_q.delete();
        m_sqx = 0;
        wait_left = 0;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (wb.cyc !== 1'b0 || wb.stb !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cyc_stb: cyc=%b stb=%b, required 0 0", wb.cyc, wb.stb);
        end
        n_vec++;
        if (wb.adr !== BASE) begin
            n_fail++;
            $display("FAIL reset_adr: got %h, required %h", wb.adr, BASE);
        end
        n_vec++;
        if (wb.dat_ms !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_dat: got %h, required 00000000", wb.dat_ms);
        end
        n_vec++;
        if (busy !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: busy=%b frame_done=%b, required 0 0", busy, frame_done);
        end
        n_vec++;
        if (wb.we !== 1'b1 || wb.sel !== 4'hF || wb.cti !== 3'b000 || wb.bte !== 2'b00) begin
            n_fail++;
            $display("FAIL bus_constants: we=%b sel=%h cti=%h bte=%h, required 1 f 0 0",
                     wb.we, wb.sel, wb.cti, wb.bte);
        end
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_bars();
        bit ok;
        rand_mode = 0;
        push_frame();
        ack_cnt = 0;
        fd_cnt = 0;
        cyc_hi_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        #1;
        n_vec++;
        if (wb.cyc !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_start_cyc: got %b, required 0", wb.cyc);
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        n_vec++;
        if (wb.cyc !== 1'b1 || wb.adr !== BASE || wb.dat_ms !== 32'h00FFFFFF) begin
            n_fail++;
            $display("FAIL start_latency: cyc=%b adr=%h dat=%h, required 1 %h 00ffffff",
                     wb.cyc, wb.adr, wb.dat_ms, BASE);
        end
        wait_fd(NPIX + 20, ok);
        n_vec++;
        if (!ok) begin
            n_fail++;
            $display("FAIL bars_timeout: frame_done not seen, required within %0d cycles", NPIX + 20);
        end
        repeat (3) @(negedge clk);
        #1;
        n_vec++;
        if (ack_cnt !== NPIX || cyc_hi_cnt !== NPIX) begin
            n_fail++;
            $display("FAIL bars_throughput: acks=%0d cyc_cycles=%0d, required %0d %0d",
                     ack_cnt, cyc_hi_cnt, NPIX, NPIX);
        end
        n_vec++;
        if (fd_cnt !== 1 || sb_q.size() !== 0) begin
            n_fail++;
            $display("FAIL bars_done_once: pulses=%0d left=%0d, required 1 0", fd_cnt, sb_q.size());
        end
    endtask

    task automatic test_random_latency();
        bit ok;
        rand_mode = 1;
        push_frame();
        ack_cnt = 0;
        pulse_start();
        wait_fd(NPIX * 7 + 20, ok);
        n_vec++;
        if (!ok) begin
            n_fail++;
            $display("FAIL random_timeout: frame_done not seen, required within %0d cycles", NPIX * 7 + 20);
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (ack_cnt !== NPIX || sb_q.size() !== 0) begin
            n_fail++;
            $display("FAIL random_count: acks=%0d left=%0d, required %0d 0", ack_cnt, sb_q.size(), NPIX);
        end
        rand_mode = 0;
        wait_left = 0;
    endtask

    task automatic test_square_wrap();
        bit ok;
        apply_reset();
        for (int k = 0; k < 5; k++) push_frame();
        @(negedge clk);
        auto_run = 1'b1;
        for (int f = 0; f < 5; f++) begin
            wait_fd(NPIX + 20, ok);
            n_vec++;
            if (!ok || wb.cyc !== 1'b0) begin
                n_fail++;
                $display("FAIL square_frame%0d_end: done=%b cyc=%b, required 1 0", f, ok, wb.cyc);
            end
            if (f < 4) begin
                @(negedge clk);
                #1;
                n_vec++;
                if (wb.cyc !== 1'b1) begin
                    n_fail++;
                    $display("FAIL auto_restart%0d: cyc=%b, required 1", f, wb.cyc);
                end
                if (f == 3) auto_run = 1'b0;
            end
        end
        repeat (3) begin
            @(negedge clk);
            #1;
            n_vec++;
            if (wb.cyc !== 1'b0) begin
                n_fail++;
                $display("FAIL square_stop: cyc=%b, required 0", wb.cyc);
            end
        end
        n_vec++;
        if (sb_q.size() !== 0) begin
            n_fail++;
            $display("FAIL square_left: got %0d, required 0", sb_q.size());
        end
    endtask

    task automatic test_start_ignored();
        bit ok;
        push_frame();
        pulse_start();
        repeat (10) @(negedge clk);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_fd(NPIX + 20, ok);
        n_vec++;
        if (!ok) begin
            n_fail++;
            $display("FAIL ignore_timeout: frame_done not seen, required within %0d cycles", NPIX + 20);
        end
        repeat (4) begin
            @(negedge clk);
            #1;
            n_vec++;
            if (wb.cyc !== 1'b0) begin
                n_fail++;
                $display("FAIL ignore_extra_frame: cyc=%b, required 0", wb.cyc);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        push_frame();
        ack_cnt = 0;
        pulse_start();
        ok = 0;
        for (int i = 0; i < NPIX; i++) begin
            @(negedge clk);
            #1;
            if (ack_cnt >= 30) begin
                ok = 1;
                break;
            end
        end
        n_vec++;
        if (!ok) begin
            n_fail++;
            $display("FAIL mid_reach_ack30: acks=%0d, required 30", ack_cnt);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (wb.cyc !== 1'b0 || wb.stb !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_ctrl: cyc=%b stb=%b busy=%b done=%b, required 0 0 0 0",
                     wb.cyc, wb.stb, busy, frame_done);
        end
        n_vec++;
        if (wb.adr !== BASE || wb.dat_ms !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_reset_bus: adr=%h dat=%h, required %h 00000000", wb.adr, wb.dat_ms, BASE);
        end
        sb_q.delete();
        m_sqx = 0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        push_frame();
        pulse_start();
        #1;
        n_vec++;
        if (wb.cyc !== 1'b1 || wb.adr !== BASE || wb.dat_ms !== 32'h00FFFFFF) begin
            n_fail++;
            $display("FAIL mid_restart: cyc=%b adr=%h dat=%h, required 1 %h 00ffffff",
                     wb.cyc, wb.adr, wb.dat_ms, BASE);
        end
        wait_fd(NPIX + 20, ok);
        n_vec++;
        if (!ok || sb_q.size() !== 0) begin
            n_fail++;
            $display("FAIL mid_restart_frame: done=%b left=%0d, required 1 0", ok, sb_q.size());
        end
    endtask

    initial begin
        wb.ack    = 1'b0;
        wb.err    = 1'b0;
        wb.rty    = 1'b0;
        wb.dat_sm = '0;
        test_reset();
        test_bars();
        test_random_latency();
        test_square_wrap();
        test_start_ignored();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

endmodule
